// File: rtl/krnl_msm_381_pkg.sv
// Types and constants shared across the MSM-381 kernel, including the
// accumulator write-back arbitration path.
package krnl_msm_381_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int C_BEAT_CNT_W = 32;

    // Index width for an N-entry vector; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotated find-first-set: returns the first request at or
// above ptr, wrapping to the lowest request index when none is found.
module rr_priority_pick
    import krnl_msm_381_pkg::*;
#(
    parameter int P_N     = 2,
    parameter int P_PTR_W = idx_width(P_N)
) (
    input  logic [P_N-1:0]     req,
    input  logic [P_PTR_W-1:0] ptr,
    output logic [P_N-1:0]     grant,
    output logic               valid
);

    logic [P_N-1:0] upper_mask;
    logic [P_N-1:0] upper_req;
    logic [P_N-1:0] pick_src;

    // Prefer requests at or above ptr, isolate the lowest set bit of the chosen set.
    always_comb begin
        upper_mask = {P_N{1'b0}};
        for (int i = 0; i < P_N; i++) begin
            upper_mask[i] = (P_PTR_W'(i) >= ptr);
        end
        upper_req = req & upper_mask;
        if (upper_req != {P_N{1'b0}}) begin
            pick_src = upper_req;
        end else begin
            pick_src = req;
        end
        grant = pick_src & (~pick_src + P_N'(1'b1));
        valid = (req != {P_N{1'b0}});
    end

endmodule

// File: rtl/bucket_frame_arbiter.sv
// Frame-granular round-robin arbiter that merges the accumulator bucket
// streams onto the single host write engine for one write-back job.
module bucket_frame_arbiter
    import krnl_msm_381_pkg::*;
#(
    parameter int P_NUM_ACCU   = 2,
    parameter int P_DATA_PNT_W = 384,
    parameter int P_CNT_W      = C_BEAT_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_start_i,
    input  logic [P_NUM_ACCU-1:0]   ctrl_mask_i,
    input  logic [P_DATA_PNT_W-1:0] s_data_i [P_NUM_ACCU],
    input  logic [P_NUM_ACCU-1:0]   s_valid_i,
    input  logic [P_NUM_ACCU-1:0]   s_last_i,
    output logic [P_NUM_ACCU-1:0]   s_ready_o,
    output logic [P_DATA_PNT_W-1:0] m_data_o,
    output logic                    m_valid_o,
    output logic                    m_last_o,
    input  logic                    m_ready_i,
    output logic                    start_host_wr_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic [P_CNT_W-1:0]      beat_cnt_o
);

    localparam int               PTR_W    = idx_width(P_NUM_ACCU);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(P_NUM_ACCU - 1);

    state_t                  state;
    logic [P_NUM_ACCU-1:0]   pending;
    logic [P_NUM_ACCU-1:0]   grant;
    logic [PTR_W-1:0]        rr_ptr;

    logic [P_NUM_ACCU-1:0]   cand;
    logic [P_NUM_ACCU-1:0]   pick_grant;
    logic                    pick_valid;
    logic [P_NUM_ACCU-1:0]   pending_clr;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic [P_DATA_PNT_W-1:0] sel_data;
    logic                    out_free;
    logic                    accept;
    logic                    last_accept;
    logic                    start_accept;

    rr_priority_pick #(
        .P_N     (P_NUM_ACCU),
        .P_PTR_W (PTR_W)
    ) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Source handshake, granted-beat mux and the frame-end bookkeeping terms.
    always_comb begin
        cand         = s_valid_i & pending;
        out_free     = ~m_valid_o | m_ready_i;
        start_accept = (state == IDLE) && ctrl_start_i;
        if ((state == XFER) && out_free) begin
            s_ready_o = grant;
        end else begin
            s_ready_o = {P_NUM_ACCU{1'b0}};
        end
        accept      = |(s_ready_o & s_valid_i);
        last_accept = accept && |(grant & s_last_i);
        pending_clr = pending & ~grant;
        sel_data    = {P_DATA_PNT_W{1'b0}};
        grant_idx   = {PTR_W{1'b0}};
        for (int i = 0; i < P_NUM_ACCU; i++) begin
            if (grant[i]) begin
                sel_data  = sel_data | s_data_i[i];
                grant_idx = grant_idx | PTR_W'(i);
            end else begin
                sel_data  = sel_data;
                grant_idx = grant_idx;
            end
        end
        if (grant_idx == LAST_IDX) begin
            next_ptr = {PTR_W{1'b0}};
        end else begin
            next_ptr = grant_idx + PTR_W'(1'b1);
        end
    end

    // Job sequencing: accept, arbitrate, hold grant for a frame, drain, report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pending         <= {P_NUM_ACCU{1'b0}};
            grant           <= {P_NUM_ACCU{1'b0}};
            rr_ptr          <= {PTR_W{1'b0}};
            start_host_wr_o <= 1'b0;
            done_o          <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            start_host_wr_o <= 1'b0;
            done_o          <= 1'b0;
            if (done_o) begin
                busy_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ctrl_start_i) begin
                        pending         <= ctrl_mask_i;
                        rr_ptr          <= {PTR_W{1'b0}};
                        start_host_wr_o <= 1'b1;
                        busy_o          <= 1'b1;
                        state           <= (ctrl_mask_i == {P_NUM_ACCU{1'b0}}) ? DRAIN : ARB;
                    end
                end
                ARB: begin
                    if (pick_valid) begin
                        grant <= pick_grant;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (last_accept) begin
                        pending <= pending_clr;
                        rr_ptr  <= next_ptr;
                        state   <= (pending_clr != {P_NUM_ACCU{1'b0}}) ? ARB : DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Single output stage; m_last marks the frame end that empties pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_o  <= {P_DATA_PNT_W{1'b0}};
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end else if (accept) begin
            m_data_o  <= sel_data;
            m_valid_o <= 1'b1;
            m_last_o  <= last_accept && (pending_clr == {P_NUM_ACCU{1'b0}});
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end
    end

    // Beats emitted on the write-engine side; cleared only by a new job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_o <= {P_CNT_W{1'b0}};
        end else if (start_accept) begin
            beat_cnt_o <= {P_CNT_W{1'b0}};
        end else if (m_valid_o && m_ready_i) begin
            beat_cnt_o <= beat_cnt_o + P_CNT_W'(1'b1);
        end
    end

endmodule

// File: tb/tb_bucket_frame_arbiter.sv
// Self-checking bench for bucket_frame_arbiter: frame-level reference model
// (frames concatenated in round-robin order) against the observed m_* stream.
module tb_bucket_frame_arbiter;

    localparam int N  = 2;
    localparam int DW = 384;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          ctrl_start_i;
    logic [N-1:0]  ctrl_mask_i;
    logic [DW-1:0] s_data_i [N];
    logic [N-1:0]  s_valid_i;
    logic [N-1:0]  s_last_i;
    logic [N-1:0]  s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic          start_host_wr_o;
    logic          done_o;
    logic          busy_o;
    logic [CW-1:0] beat_cnt_o;

    int n_checks;
    int n_fail;

    bucket_frame_arbiter #(
        .P_NUM_ACCU   (N),
        .P_DATA_PNT_W (DW),
        .P_CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_start_i    (ctrl_start_i),
        .ctrl_mask_i     (ctrl_mask_i),
        .s_data_i        (s_data_i),
        .s_valid_i       (s_valid_i),
        .s_last_i        (s_last_i),
        .s_ready_o       (s_ready_o),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_last_o        (m_last_o),
        .m_ready_i       (m_ready_i),
        .start_host_wr_o (start_host_wr_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .beat_cnt_o      (beat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic drive_idle();
        ctrl_start_i = 1'b0;
        ctrl_mask_i  = '0;
        s_valid_i    = '0;
        s_last_i     = '0;
        m_ready_i    = 1'b1;
        for (int i = 0; i < N; i++) s_data_i[i] = '0;
    endtask

    // One job: stream i offers len[i] beats from cycle dly[i]; rdy_mode 0=always,
    // 1=toggle 1010.., 2=random. Expected stream = masked frames in RR order from 'first'.
    task automatic run_job(input string name, input logic [N-1:0] mask,
                           input int len0, input int len1, input int dly0, input int dly1,
                           input int rdy_mode, input bit gaps, input int first, input bit timing_chk);
        logic [DW-1:0] src [N][8];
        logic [DW:0]   exp_q[$];
        logic [DW:0]   held;
        logic [DW:0]   got;
        int len [N];
        int dly [N];
        int pos [N];
        bit hold [N];
        bit fired [N];
        bit stall;
        int cyc, done_cyc, n_done, first_fire, first_mv, last_mv, n_mv, total, nf, idx;
        len[0] = len0; len[1] = len1; dly[0] = dly0; dly[1] = dly1;
        total = 0; nf = 0; n_done = 0; n_mv = 0;
        done_cyc = -1; first_fire = -1; first_mv = -1; last_mv = -1;
        stall = 1'b0; held = '0;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0; hold[i] = 1'b0; fired[i] = 1'b0;
            for (int k = 0; k < 8; k++) src[i][k] = rand_beat();
        end
        for (int j = 0; j < N; j++) begin
            idx = (first + j) % N;
            if (mask[idx]) begin
                nf++;
                total += len[idx];
                for (int k = 0; k < len[idx]; k++) exp_q.push_back({1'b0, src[idx][k]});
            end
        end
        if (exp_q.size() > 0) begin
            got = exp_q.pop_back();
            got[DW] = 1'b1;
            exp_q.push_back(got);
        end

        @(negedge clk);
        ctrl_start_i = 1'b1;
        ctrl_mask_i  = mask;
        cyc = 0;
        while (1) begin
            for (int i = 0; i < N; i++) begin
                if (pos[i] < len[i] && cyc >= dly[i]) begin
                    if (!hold[i]) hold[i] = (pos[i] == 0) || !gaps || ($urandom_range(2, 0) != 0);
                end else begin
                    hold[i] = 1'b0;
                end
                s_valid_i[i] = hold[i];
                s_data_i[i]  = (pos[i] < len[i]) ? src[i][pos[i]] : '0;
                s_last_i[i]  = hold[i] && (pos[i] == len[i] - 1);
            end
            if (rdy_mode == 0) m_ready_i = 1'b1;
            else if (rdy_mode == 1) m_ready_i = (cyc % 2 == 0);
            else m_ready_i = ($urandom_range(1, 0) == 1);

            #1;
            n_checks++;
            if (start_host_wr_o !== (cyc == 1)) begin
                n_fail++;
                $display("FAIL %s start_pulse cyc=%0d: got %b want %b", name, cyc, start_host_wr_o, (cyc == 1));
            end
            for (int i = 0; i < N; i++) begin
                if (!mask[i]) begin
                    n_checks++;
                    if (s_ready_o[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s unmasked_ready[%0d] cyc=%0d: got %b want 0", name, i, cyc, s_ready_o[i]);
                    end
                end
            end
            if (stall) begin
                n_checks++;
                if (m_valid_o !== 1'b1 || {m_last_o, m_data_o} !== held) begin
                    n_fail++;
                    $display("FAIL %s stall_hold cyc=%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", name, cyc,
                             m_valid_o, m_last_o, m_data_o[63:0], held[DW], held[63:0]);
                end
            end
            if (m_valid_o === 1'b1) begin
                n_mv++;
                if (first_mv < 0) first_mv = cyc;
                last_mv = cyc;
                if (m_ready_i) begin
                    if (first_fire < 0) first_fire = cyc;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_beat cyc=%0d: got d=%h want no beat", name, cyc, m_data_o[63:0]);
                    end else begin
                        got = exp_q.pop_front();
                        if ({m_last_o, m_data_o} !== got) begin
                            n_fail++;
                            $display("FAIL %s beat cyc=%0d: got l=%b d=%h want l=%b d=%h", name, cyc,
                                     m_last_o, m_data_o[63:0], got[DW], got[63:0]);
                        end
                    end
                end
            end
            if (done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc >= 1 && (done_cyc < 0 || cyc == done_cyc)) begin
                n_checks++;
                if (busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_high cyc=%0d: got %b want 1", name, cyc, busy_o);
                end
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                n_checks++;
                if (busy_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_low cyc=%0d: got %b want 0", name, cyc, busy_o);
                end
            end
            for (int i = 0; i < N; i++) fired[i] = (s_valid_i[i] && s_ready_o[i] === 1'b1);
            stall = (m_valid_o === 1'b1) && !m_ready_i;
            held  = {m_last_o, m_data_o};
            if ((done_cyc >= 0 && cyc >= done_cyc + 1) || cyc >= 300) break;

            @(negedge clk);
            ctrl_start_i = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (fired[i]) begin
                    pos[i]++;
                    hold[i] = 1'b0;
                end
            end
            cyc++;
        end

        n_checks++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL %s done_timeout: got no done_o within %0d cycles want done_o", name, cyc);
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d want 1", name, n_done);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_beats: got %0d left want 0", name, exp_q.size());
        end
        n_checks++;
        if (beat_cnt_o !== CW'(total)) begin
            n_fail++;
            $display("FAIL %s beat_cnt: got %0d want %0d", name, beat_cnt_o, total);
        end
        if (timing_chk) begin
            if (mask == '0) begin
                n_checks++;
                if (done_cyc != 2 || n_mv != 0) begin
                    n_fail++;
                    $display("FAIL %s empty_mask: got done_cyc=%0d m_valid_cycles=%0d want 2 and 0", name, done_cyc, n_mv);
                end
            end else begin
                n_checks++;
                if (first_fire != 3) begin
                    n_fail++;
                    $display("FAIL %s first_beat_cyc: got %0d want 3", name, first_fire);
                end
                n_checks++;
                if (done_cyc != total + nf + 2) begin
                    n_fail++;
                    $display("FAIL %s done_cyc: got %0d want %0d", name, done_cyc, total + nf + 2);
                end
                n_checks++;
                if ((last_mv - first_mv + 1) - n_mv != nf - 1) begin
                    n_fail++;
                    $display("FAIL %s bubbles: got %0d want %0d", name, (last_mv - first_mv + 1) - n_mv, nf - 1);
                end
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_valid_o, m_last_o, start_host_wr_o, done_o, busy_o} !== 5'b0 || m_data_o !== '0 ||
            beat_cnt_o !== '0 || s_ready_o !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b l=%b st=%b dn=%b bz=%b cnt=%0d rdy=%b want all 0",
                     m_valid_o, m_last_o, start_host_wr_o, done_o, busy_o, beat_cnt_o, s_ready_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_streams();
        run_job("two_streams", 2'b11, 4, 3, 0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_round_robin();
        run_job("round_robin", 2'b11, 3, 3, 6, 0, 0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_back_pressure();
        run_job("back_pressure", 2'b01, 5, 0, 0, 0, 1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mask_single();
        run_job("mask_01", 2'b01, 3, 6, 0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_mask_empty();
        run_job("mask_00", 2'b00, 2, 2, 0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int fires;
        int c;
        fires = 0;
        c = 0;
        @(negedge clk);
        ctrl_start_i = 1'b1;
        ctrl_mask_i  = 2'b01;
        s_valid_i    = 2'b01;
        s_last_i     = 2'b00;
        s_data_i[0]  = rand_beat();
        m_ready_i    = 1'b1;
        while (fires < 2 && c < 20) begin
            #1;
            if (m_valid_o === 1'b1 && m_ready_i) fires++;
            @(negedge clk);
            ctrl_start_i = 1'b0;
            s_data_i[0]  = rand_beat();
            c++;
        end
        n_checks++;
        if (fires != 2) begin
            n_fail++;
            $display("FAIL reset_mid_frame_setup: got %0d beats want 2", fires);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({m_valid_o, m_last_o, start_host_wr_o, done_o, busy_o} !== 5'b0 || m_data_o !== '0 ||
            beat_cnt_o !== '0 || s_ready_o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_values: got v=%b l=%b st=%b dn=%b bz=%b cnt=%0d rdy=%b want all 0",
                     m_valid_o, m_last_o, start_host_wr_o, done_o, busy_o, beat_cnt_o, s_ready_o);
        end
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (beat_cnt_o !== '0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_release: got cnt=%0d done=%b want 0 and 0", beat_cnt_o, done_o);
        end
        run_job("after_reset", 2'b01, 3, 2, 0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        for (int t = 0; t < 8; t++) begin
            mask = N'($urandom_range(3, 0));
            run_job("random", mask, $urandom_range(6, 1), $urandom_range(6, 1), 0, 0, 2, 1'b1, 0, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        test_reset();
        test_two_streams();
        test_round_robin();
        test_back_pressure();
        test_mask_single();
        test_mask_empty();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
